bp_clint_slice: RTL

//  Single-hart CLINT device behind the 0x02xx_xxxx window: holds msip, mtimecmp, mtime.

---
 rtl/bp_clint_slice.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bp_clint_slice.sv
// Single-hart CLINT slice: msip, mtimecmp and mtime behind decoded MMIO, one response per request.
// Optional BP_CLINT_PRESCALE_EN divides the mtime tick by prescale_p.
module bp_clint_slice #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int prescale_p   = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [1:0]              size_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    err_o,
  input  logic                    yumi_i,
  output logic                    software_irq_o,
  output logic                    timer_irq_o
);

  typedef enum logic {e_idle, e_resp} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             mtime_q, mtime_d;
  logic [63:0]             mtimecmp_q, mtimecmp_d;
  logic                    msip_q, msip_d;
  logic                    timer_irq_q;
  logic [data_width_p-1:0] data_q, data_d;
  logic                    err_q, err_d;
  logic                    tick;

`ifdef BP_CLINT_PRESCALE_EN
  localparam int cnt_w_lp = (prescale_p > 1) ? $clog2(prescale_p) : 1;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == cnt_w_lp'(prescale_p - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign tick = 1'b1;
`endif

  logic [31:0] addr;
  logic        is4, is8;
  logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_cmp_full;
  logic        hit_time_lo, hit_time_hi, hit_time_full, hit_any;
  logic [63:0] rd_data;

  // Exact address match per size also enforces alignment.
  assign addr          = addr_i[31:0];
  assign is4           = (size_i == 2'b10);
  assign is8           = (size_i == 2'b11);
  assign hit_msip      = is4 & (addr == 32'h0200_0000);
  assign hit_cmp_lo    = is4 & (addr == 32'h0200_4000);
  assign hit_cmp_hi    = is4 & (addr == 32'h0200_4004);
  assign hit_cmp_full  = is8 & (addr == 32'h0200_4000);
  assign hit_time_lo   = is4 & (addr == 32'h0200_BFF8);
  assign hit_time_hi   = is4 & (addr == 32'h0200_BFFC);
  assign hit_time_full = is8 & (addr == 32'h0200_BFF8);
  assign hit_any       = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_cmp_full
                       | hit_time_lo | hit_time_hi | hit_time_full;

  always_comb begin
    rd_data = 64'h0;
    if (hit_msip)      rd_data = {63'h0, msip_q};
    if (hit_cmp_lo)    rd_data = {32'h0, mtimecmp_q[31:0]};
    if (hit_cmp_hi)    rd_data = {32'h0, mtimecmp_q[63:32]};
    if (hit_cmp_full)  rd_data = mtimecmp_q;
    if (hit_time_lo)   rd_data = {32'h0, mtime_q[31:0]};
    if (hit_time_hi)   rd_data = {32'h0, mtime_q[63:32]};
    if (hit_time_full) rd_data = mtime_q;
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    err_d      = err_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    case (state_q)
      e_idle: begin
        if (v_i) begin
          state_d = e_resp;
          err_d   = ~hit_any;
          data_d  = w_i ? '0 : data_width_p'(rd_data);
          // A write to mtime overrides this cycle's tick; partial writes keep the other pre-tick half.
          if (w_i) begin
            if (hit_msip)      msip_d     = data_i[0];
            if (hit_cmp_lo)    mtimecmp_d = {mtimecmp_q[63:32], data_i[31:0]};
            if (hit_cmp_hi)    mtimecmp_d = {data_i[31:0], mtimecmp_q[31:0]};
            if (hit_cmp_full)  mtimecmp_d = 64'(data_i);
            if (hit_time_lo)   mtime_d    = {mtime_q[63:32], data_i[31:0]};
            if (hit_time_hi)   mtime_d    = {data_i[31:0], mtime_q[31:0]};
            if (hit_time_full) mtime_d    = 64'(data_i);
          end
        end
      end
      e_resp: begin
        if (yumi_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign ready_o        = (state_q == e_idle);
  assign v_o            = (state_q == e_resp);
  assign data_o         = data_q;
  assign err_o          = err_q;
  assign software_irq_o = msip_q;
  assign timer_irq_o    = timer_irq_q;

endmodule
